// File: rtl/axi4stream_gen_mst.sv
// AXI4-Stream traffic generator master: emits cfg_pkts packets of cfg_len beats
// carrying an incrementing beat count, with optional LFSR-driven tvalid gaps.
module axi4stream_gen_mst #(
  parameter int          DATA_WIDTH = 8,
  parameter int          LEN_WIDTH  = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cfg_start,
  input  logic [LEN_WIDTH-1:0]    cfg_len,
  input  logic [7:0]              cfg_pkts,
  input  logic                    cfg_throttle,
  input  logic [DATA_WIDTH/8-1:0] cfg_last_keep,
  output logic                    sts_busy,
  output logic                    sts_done,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast
);

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  state_t                  state;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [7:0]              pkts_q;
  logic                    thr_q;
  logic [DATA_WIDTH/8-1:0] keep_q;
  logic [LEN_WIDTH-1:0]    bip;
  logic [7:0]              pkt_cnt;
  logic [15:0]             lfsr;

  logic [LEN_WIDTH-1:0]    len_eff;
  logic [LEN_WIDTH-1:0]    bip_nxt;
  logic                    last_nxt;
  logic                    first_last;
  logic                    gen_valid;
  logic                    hs;
  logic                    lfsr_fb;

  always_comb begin
    len_eff    = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
    first_last = (len_eff == LEN_WIDTH'(1));
    bip_nxt    = m_axis_tlast ? '0 : bip + LEN_WIDTH'(1);
    last_nxt   = (bip_nxt == len_q - LEN_WIDTH'(1));
    gen_valid  = thr_q ? lfsr[0] : 1'b1;
    hs         = m_axis_tvalid & m_axis_tready;
    lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  end

  // tdata doubles as the run-global beat counter; payload regs only move on a
  // handshake, which keeps them stable while stalled or throttled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      len_q         <= '0;
      pkts_q        <= '0;
      thr_q         <= 1'b0;
      keep_q        <= '0;
      bip           <= '0;
      pkt_cnt       <= '0;
      lfsr          <= LFSR_SEED;
      sts_busy      <= 1'b0;
      sts_done      <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          m_axis_tvalid <= 1'b0;
          if (cfg_start) begin
            len_q        <= len_eff;
            pkts_q       <= cfg_pkts;
            thr_q        <= cfg_throttle;
            keep_q       <= cfg_last_keep;
            bip          <= '0;
            pkt_cnt      <= '0;
            m_axis_tdata <= '0;
            if (cfg_pkts != 8'd0) begin
              state         <= SEND;
              sts_busy      <= 1'b1;
              m_axis_tvalid <= cfg_throttle ? lfsr[0] : 1'b1;
              m_axis_tlast  <= first_last;
              m_axis_tkeep  <= first_last ? cfg_last_keep : '1;
            end else begin
              state    <= FIN;
              sts_done <= 1'b1;
            end
          end
        end
        SEND: begin
          lfsr <= {lfsr[14:0], lfsr_fb};
          if (hs) begin
            m_axis_tdata <= m_axis_tdata + DATA_WIDTH'(1);
            bip          <= bip_nxt;
            if (m_axis_tlast && (pkt_cnt == pkts_q - 8'd1)) begin
              state         <= FIN;
              sts_busy      <= 1'b0;
              sts_done      <= 1'b1;
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
            end else begin
              if (m_axis_tlast) pkt_cnt <= pkt_cnt + 8'd1;
              m_axis_tvalid <= gen_valid;
              m_axis_tlast  <= last_nxt;
              m_axis_tkeep  <= last_nxt ? keep_q : '1;
            end
          end else if (!m_axis_tvalid) begin
            m_axis_tvalid <= gen_valid;
          end
        end
        FIN: begin
          sts_done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4stream_gen_mst.sv
// Bench for axi4stream_gen_mst: a packet-list scoreboard checked every cycle,
// plus directed scenarios with literal expectations.
module tb_axi4stream_gen_mst;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_len = 16'd0;
  logic [7:0]  cfg_pkts = 8'd0;
  logic        cfg_throttle = 1'b0;
  logic [0:0]  cfg_last_keep = 1'b0;
  logic        sts_busy, sts_done, tvalid, tlast;
  logic        tready = 1'b1;
  logic [7:0]  tdata;
  logic [0:0]  tkeep;

  logic        start32 = 1'b0;
  logic [3:0]  keep32 = 4'h0;
  logic        busy32, done32, tvalid32, tlast32;
  logic        tready32 = 1'b1;
  logic [31:0] tdata32;
  logic [3:0]  tkeep32;

  always #5 aclk = ~aclk;

  axi4stream_gen_mst #(.DATA_WIDTH(8), .LEN_WIDTH(16), .LFSR_SEED(16'hACE1)) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .cfg_pkts(cfg_pkts), .cfg_throttle(cfg_throttle), .cfg_last_keep(cfg_last_keep),
    .sts_busy(sts_busy), .sts_done(sts_done), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tdata(tdata), .m_axis_tkeep(tkeep),
    .m_axis_tlast(tlast));

  axi4stream_gen_mst #(.DATA_WIDTH(32), .LEN_WIDTH(16), .LFSR_SEED(16'hACE1)) dut32 (
    .aclk(aclk), .aresetn(aresetn), .cfg_start(start32), .cfg_len(cfg_len),
    .cfg_pkts(cfg_pkts), .cfg_throttle(1'b0), .cfg_last_keep(keep32),
    .sts_busy(busy32), .sts_done(done32), .m_axis_tvalid(tvalid32),
    .m_axis_tready(tready32), .m_axis_tdata(tdata32), .m_axis_tkeep(tkeep32),
    .m_axis_tlast(tlast32));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected beat list for the current run
  typedef struct { int data; bit last; int keep; } beat_t;
  beat_t q[$];
  bit    run_active = 0;
  bit    done_exp = 0;
  bit    thr_m = 0;
  int    cyc = 0;
  int    hs_total = 0;
  int    done_cnt = 0;
  int    last_hs_cyc = 0, last_done_cyc = 0, start_cyc = 0;
  int    log_data [0:1023];
  bit    log_last [0:1023];
  int    stall_log [0:1023];
  int    stall_run = 0;
  bit    prev_stall = 0;
  logic [7:0] prev_data;
  logic       prev_last;
  logic [0:0] prev_keep;

  always @(negedge aclk) begin
    bit was_active, new_done;
    int len_e;
    cyc++;
    if (!aresetn) begin
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tdata", tdata, 0);
      chk("rst_tkeep", tkeep, 0);
      chk("rst_tlast", tlast, 0);
      chk("rst_busy", sts_busy, 0);
      chk("rst_done", sts_done, 0);
      q.delete();
      run_active = 0;
      done_exp = 0;
      prev_stall = 0;
      stall_run = 0;
    end else begin
      was_active = run_active;
      new_done = 0;
      chk("busy", sts_busy, run_active);
      chk("done", sts_done, done_exp);
      if (sts_done) begin
        last_done_cyc = cyc;
        done_cnt++;
      end
      if (!run_active) chk("idle_tvalid", tvalid, 0);
      else if (!thr_m) chk("cont_tvalid", tvalid, 1);
      if (prev_stall) begin
        chk("hold_tvalid", tvalid, 1);
        chk("hold_tdata", tdata, prev_data);
        chk("hold_tlast", tlast, prev_last);
        chk("hold_tkeep", tkeep, prev_keep);
      end
      if (tvalid && q.size() == 0) chk("beat_unexpected", tvalid, 0);
      if (tvalid && q.size() > 0) begin
        chk("tdata", tdata, q[0].data);
        chk("tlast", tlast, q[0].last);
        chk("tkeep", tkeep, q[0].keep);
        if (tready) begin
          log_data[hs_total] = tdata;
          log_last[hs_total] = tlast;
          stall_log[hs_total] = stall_run;
          stall_run = 0;
          hs_total++;
          last_hs_cyc = cyc;
          void'(q.pop_front());
          if (q.size() == 0) begin
            run_active = 0;
            new_done = 1;
          end
        end else begin
          stall_run++;
        end
      end
      prev_stall = tvalid && !tready;
      prev_data = tdata;
      prev_last = tlast;
      prev_keep = tkeep;
      if (cfg_start && !was_active && !done_exp) begin
        start_cyc = cyc;
        thr_m = cfg_throttle;
        len_e = (cfg_len == 0) ? 1 : int'(cfg_len);
        if (cfg_pkts == 0) new_done = 1;
        else begin
          for (int p = 0; p < int'(cfg_pkts); p++)
            for (int b = 0; b < len_e; b++) begin
              beat_t e;
              e.data = (p * len_e + b) % 256;
              e.last = (b == len_e - 1);
              e.keep = e.last ? int'(cfg_last_keep) : 1;
              q.push_back(e);
            end
          run_active = 1;
        end
      end
      done_exp = new_done;
    end
  end

  // tready driver: 0 = always ready, 1 = random, 2 = five-cycle stall on tdata==2
  int rdy_mode = 0;
  int stall_done = 0;
  always @(posedge aclk) begin
    #1;
    case (rdy_mode)
      1: tready = 1'($urandom_range(0, 1));
      2: begin
        if (tvalid && tdata == 8'd2 && stall_done < 5) begin
          tready = 1'b0;
          stall_done++;
        end else tready = 1'b1;
      end
      default: begin
        tready = 1'b1;
        stall_done = 0;
      end
    endcase
  end

  int        cap_n = 0;
  logic [3:0] cap_keep [0:7];
  always @(negedge aclk) begin
    if (aresetn && tvalid32 && cap_n < 8) begin
      cap_keep[cap_n] = tkeep32;
      cap_n++;
    end
  end

  task automatic start(input int len, input int pkts, input bit thr, input bit keep);
    @(posedge aclk); #1;
    cfg_len = 16'(len);
    cfg_pkts = 8'(pkts);
    cfg_throttle = thr;
    cfg_last_keep = keep;
    cfg_start = 1'b1;
    @(posedge aclk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string name);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge aclk); #1;
      if (!run_active && !done_exp) begin
        ok = 1;
        break;
      end
    end
    chk(name, ok, 1);
  endtask

  initial begin
    int base;
    int dc;
    bit ok;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;

    // two packets of four beats, continuous
    base = hs_total;
    start(4, 2, 0, 1);
    wait_end(200, "t1_timeout");
    chk("t1_count", hs_total - base, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_data", log_data[base + i], i);
      chk("t1_last", log_last[base + i], (i % 4) == 3);
    end
    chk("t1_done_lat", last_done_cyc - last_hs_cyc, 1);

    // back-pressure on beat 2
    rdy_mode = 2;
    base = hs_total;
    start(6, 1, 0, 1);
    wait_end(200, "t2_timeout");
    rdy_mode = 0;
    chk("t2_stall_len", stall_log[base + 2], 5);
    chk("t2_beat2", log_data[base + 2], 2);
    chk("t2_count", hs_total - base, 6);

    // 32-bit instance: last-beat keep
    @(posedge aclk); #1;
    cfg_len = 16'd3; cfg_pkts = 8'd1; keep32 = 4'b0011; start32 = 1'b1;
    @(posedge aclk); #1;
    start32 = 1'b0;
    repeat (10) @(posedge aclk);
    chk("t3_beats", cap_n, 3);
    chk("t3_keep0", cap_keep[0], 4'hF);
    chk("t3_keep1", cap_keep[1], 4'hF);
    chk("t3_keep2", cap_keep[2], 4'h3);

    // throttle with random back-pressure
    rdy_mode = 1;
    base = hs_total;
    start(16, 4, 1, 1);
    wait_end(5000, "t4_timeout");
    rdy_mode = 0;
    chk("t4_count", hs_total - base, 64);
    chk("t4_first", log_data[base], 0);
    chk("t4_pkt2", log_data[base + 16], 16);
    chk("t4_lastb", log_data[base + 63], 63);
    chk("t4_tlast15", log_last[base + 15], 1);

    // zero packets
    base = hs_total;
    start(5, 0, 0, 1);
    wait_end(20, "t5_timeout");
    chk("t5_count", hs_total - base, 0);
    chk("t5_done_lat", last_done_cyc - start_cyc, 1);

    // start during a run is ignored
    base = hs_total;
    start(4, 2, 0, 0);
    repeat (2) @(posedge aclk);
    #1;
    cfg_len = 16'd9; cfg_pkts = 8'd5; cfg_start = 1'b1;
    @(posedge aclk); #1;
    cfg_start = 1'b0;
    wait_end(200, "t6_timeout");
    chk("t6_count", hs_total - base, 8);

    // reset at beat 5 of a 10-beat run
    base = hs_total;
    dc = done_cnt;
    start(10, 1, 0, 1);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge aclk); #1;
      if (hs_total - base == 5) begin
        ok = 1;
        break;
      end
    end
    chk("t7_reach5", ok, 1);
    chk("t7_beat5", tdata, 5);
    aresetn = 1'b0;
    #1;
    chk("t7_async_tvalid", tvalid, 0);
    chk("t7_async_tdata", tdata, 0);
    chk("t7_async_busy", sts_busy, 0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    repeat (4) @(posedge aclk);
    chk("t7_no_done", done_cnt - dc, 0);
    base = hs_total;
    start(3, 1, 0, 1);
    wait_end(100, "t7_timeout");
    chk("t7_restart0", log_data[base], 0);
    chk("t7_count", hs_total - base, 3);

    repeat (3) @(posedge aclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4stream_gen_mst.md
AXI4STREAM_GEN_MST -- requirements
Module: axi4stream_gen_mst

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the tdata width in bits (a multiple of 8, range 8..512).
REQ-002 SHALL have parameter LEN_WIDTH, default 16, giving the width of the beat-count configuration field.
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, giving the non-zero reset value of the throttle LFSR.
REQ-004 SHALL have port aclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port aresetn, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port cfg_start, input, 1 bit: single-cycle run request.
REQ-007 SHALL have port cfg_len, input, LEN_WIDTH bits: beats per packet.
REQ-008 SHALL have port cfg_pkts, input, 8 bits: packets per run.
REQ-009 SHALL have port cfg_throttle, input, 1 bit: 1 = pseudo-random tvalid gaps.
REQ-010 SHALL have port cfg_last_keep, input, DATA_WIDTH/8 bits: tkeep value for tlast beats.
REQ-011 SHALL have port sts_busy, output, 1 bit: run in progress.
REQ-012 SHALL have port sts_done, output, 1 bit: one-cycle pulse at end of run.
REQ-013 SHALL have port m_axis_tvalid, output, 1 bit.
REQ-014 SHALL have port m_axis_tready, input, 1 bit.
REQ-015 SHALL have port m_axis_tdata, output, DATA_WIDTH bits.
REQ-016 SHALL have port m_axis_tkeep, output, DATA_WIDTH/8 bits.
REQ-017 SHALL have port m_axis_tlast, output, 1 bit.

Function
REQ-018 SHALL implement FSM states IDLE, SEND and FIN.
- IDLE -> SEND on cfg_start=1 with cfg_pkts!=0.
- IDLE -> FIN on cfg_start=1 with cfg_pkts=0.
- SEND -> FIN on the handshake of the last beat of the last packet.
- FIN -> IDLE unconditionally after one cycle.
REQ-019 SHALL sample cfg_len, cfg_pkts, cfg_throttle and cfg_last_keep on the accepted cfg_start and hold them internally for the whole run; a cfg_len of 0 SHALL be treated as 1.
REQ-020 SHALL ignore cfg_start whenever the state is not IDLE.
REQ-021 SHALL drive sts_busy=1 exactly while the state is SEND, and sts_done=1 exactly for the one cycle spent in FIN.
REQ-022 SHALL register all outputs; the earliest m_axis_tvalid=1 is the cycle after cfg_start is accepted.
REQ-023 SHALL count a handshake only on a rising aclk edge with m_axis_tvalid=1 and m_axis_tready=1.
REQ-024 SHALL hold m_axis_tvalid, tdata, tkeep and tlast stable from the assertion of tvalid until the handshake, regardless of throttle state.
REQ-025 SHALL, with throttle off, keep tvalid=1 continuously in SEND, giving one beat per cycle when tready=1.
REQ-026 SHALL, with throttle on, use a 16-bit Fibonacci LFSR (taps 16,14,13,11) stepped every cycle in SEND; while tvalid=0 it raises tvalid on the next edge only if lfsr[0]=1.
REQ-027 SHALL drive tdata from a run-global beat counter that starts at 0 and increments by 1 per handshake; the counter is zero-extended (or truncated modulo 2^DATA_WIDTH) to DATA_WIDTH and wraps silently.
REQ-028 SHALL assert tlast on beat cfg_len-1 of each packet; the beat-in-packet counter returns to 0 after the tlast handshake.
REQ-029 SHALL drive tkeep to all ones on non-last beats and to the latched cfg_last_keep on tlast beats.
REQ-030 SHALL, when the tlast handshake of a non-final packet occurs, present the first beat of the next packet with no idle cycle (throttle off).
REQ-031 SHALL drive tvalid=0 in IDLE and FIN.

Reset
REQ-032 SHALL, on aresetn=0 at any time including mid-packet, immediately force: state IDLE, tvalid=0, tlast=0, tdata=0, tkeep=0, sts_busy=0, sts_done=0, all counters 0, LFSR=LFSR_SEED.
REQ-033 SHALL produce no sts_done pulse for a run aborted by reset, and the first cfg_start after release SHALL restart tdata at 0.

Verification
REQ-034 SHALL verify: DATA_WIDTH=8, cfg_len=4, cfg_pkts=2, throttle off, tready=1 -> 8 consecutive beats with tdata 0..7, tlast on tdata 3 and 7, sts_done one cycle after beat 7.
REQ-035 SHALL verify: tready=0 for 5 cycles during beat 2 -> tvalid=1 and tdata=2 held unchanged for all 5 cycles, beat 2 accepted on the first tready=1.
REQ-036 SHALL verify: DATA_WIDTH=32, cfg_len=3, cfg_last_keep=4'b0011 -> tkeep is 4'hF, 4'hF, 4'h3.
REQ-037 SHALL verify: throttle on with random tready, cfg_len=16, cfg_pkts=4 -> exactly 64 handshakes, tdata 0..63 in order, no change of tvalid or data while stalled.
REQ-038 SHALL verify: cfg_pkts=0 -> no tvalid, sts_done pulses one cycle after cfg_start; a cfg_start issued during a run is ignored and the beat count is unchanged.
REQ-039 SHALL verify: aresetn asserted at beat 5 of a 10-beat run -> all outputs 0 asynchronously, no sts_done pulse; a restart after release begins at tdata=0.
